// File: rtl/core_seq_pkg.sv
// rtl/core_seq_pkg.sv - shared encodings for the RV32I multicycle sequencer
package core_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_TRAP      = 3'd6
    } seq_state_t;

    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    localparam logic [1:0] PC_SEL_PLUS4 = 2'b00;
    localparam logic [1:0] PC_SEL_REL   = 2'b01;
    localparam logic [1:0] PC_SEL_JALR  = 2'b10;

    localparam logic [1:0] CAUSE_SYSTEM   = 2'b00;
    localparam logic [1:0] CAUSE_FETCH_TO = 2'b01;
    localparam logic [1:0] CAUSE_DATA_TO  = 2'b10;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

    // SYSTEM is deliberately excluded: it is handled as its own trap cause
    function automatic logic is_legal_opcode(input logic [6:0] op);
        case (op)
            OP_OP, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_MISC_MEM: is_legal_opcode = 1'b1;
            default:                                         is_legal_opcode = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - consecutive wait-cycle counter for memory acknowledges
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_clear,
    input  logic i_count_en,
    output logic o_expired
);

    localparam int CW = $clog2(MEM_TIMEOUT) + 1;

    logic [CW-1:0] r_wait_cnt;

    // count unacknowledged wait cycles; clear dominates so a fresh wait always starts at zero
    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_wait_cnt <= '0;
        end else if (i_count_en) begin
            r_wait_cnt <= r_wait_cnt + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // expired marks the last cycle the requester may still wait for an ack
    assign o_expired = (r_wait_cnt == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - multicycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK control sequencer
module core_sequencer
    import core_seq_pkg::*;
#(
    parameter int MEM_TIMEOUT   = 16,
    parameter int INSTRET_WIDTH = 32
) (
    input  logic                     pll_1_200MHz,
    input  logic                     pll_1_reset_synced,
    input  logic                     run_enable,
    input  logic                     imem_ack,
    input  logic                     dmem_ack,
    input  logic [6:0]               opcode,
    input  logic                     ctl_reg_write,
    input  logic                     ctl_mem_read,
    input  logic                     ctl_mem_write,
    input  logic                     ctl_branch,
    input  logic                     ctl_jump,
    input  logic                     branch_taken,
    output logic                     imem_req,
    output logic                     ir_load,
    output logic                     dmem_req,
    output logic                     dmem_we,
    output logic                     reg_write_en,
    output logic                     pc_write,
    output logic [1:0]               pc_sel,
    output logic                     trap,
    output logic [1:0]               trap_cause,
    output logic [INSTRET_WIDTH-1:0] instret,
    output logic [2:0]               seq_state
);

    seq_state_t               r_state;
    logic [INSTRET_WIDTH-1:0] r_instret;
    logic [1:0]               r_trap_cause;

    logic w_expired;
    logic w_wait_clear;
    logic w_wait_count;

    // one timer serves both waits; it is held clear outside FETCH/MEMORY so each entry starts fresh
    assign w_wait_clear = pll_1_reset_synced ||
                          !((r_state == ST_FETCH) || (r_state == ST_MEMORY));
    assign w_wait_count = ((r_state == ST_FETCH)  && !imem_ack) ||
                          ((r_state == ST_MEMORY) && !dmem_ack);

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .i_clk      (pll_1_200MHz),
        .i_clear    (w_wait_clear),
        .i_count_en (w_wait_count),
        .o_expired  (w_expired)
    );

    // main sequencer: reset wins everywhere, TRAP is left only through reset
    always_ff @(posedge pll_1_200MHz) begin
        if (pll_1_reset_synced) begin
            r_state      <= ST_IDLE;
            r_instret    <= '0;
            r_trap_cause <= CAUSE_SYSTEM;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (run_enable) r_state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        r_state <= ST_DECODE;
                    end else if (w_expired) begin
                        r_state      <= ST_TRAP;
                        r_trap_cause <= CAUSE_FETCH_TO;
                    end
                end
                ST_DECODE: begin
                    if (opcode == OP_SYSTEM) begin
                        r_state      <= ST_TRAP;
                        r_trap_cause <= CAUSE_SYSTEM;
                    end else if (is_legal_opcode(opcode)) begin
                        r_state <= ST_EXECUTE;
                    end else begin
                        r_state      <= ST_TRAP;
                        r_trap_cause <= CAUSE_ILLEGAL;
                    end
                end
                ST_EXECUTE: begin
                    r_state <= (ctl_mem_read || ctl_mem_write) ? ST_MEMORY : ST_WRITEBACK;
                end
                ST_MEMORY: begin
                    if (dmem_ack) begin
                        r_state <= ST_WRITEBACK;
                    end else if (w_expired) begin
                        r_state      <= ST_TRAP;
                        r_trap_cause <= CAUSE_DATA_TO;
                    end
                end
                ST_WRITEBACK: begin
                    r_instret <= r_instret + {{(INSTRET_WIDTH-1){1'b0}}, 1'b1};
                    r_state   <= run_enable ? ST_FETCH : ST_IDLE;
                end
                ST_TRAP: begin
                    r_state <= ST_TRAP;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // strobes and requests decode directly from state so they align with the acks of the same cycle
    always_comb begin
        imem_req     = 1'b0;
        ir_load      = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        reg_write_en = 1'b0;
        pc_write     = 1'b0;
        pc_sel       = PC_SEL_PLUS4;
        case (r_state)
            ST_FETCH: begin
                imem_req = 1'b1;
                ir_load  = imem_ack;
            end
            ST_MEMORY: begin
                dmem_req = 1'b1;
                dmem_we  = ctl_mem_write;
            end
            ST_WRITEBACK: begin
                reg_write_en = ctl_reg_write;
                pc_write     = 1'b1;
                if (ctl_jump && (opcode == OP_JALR)) begin
                    pc_sel = PC_SEL_JALR;
                end else if (ctl_jump || (ctl_branch && branch_taken)) begin
                    pc_sel = PC_SEL_REL;
                end
            end
            default: begin
            end
        endcase
    end

    assign trap       = (r_state == ST_TRAP);
    assign trap_cause = r_trap_cause;
    assign instret    = r_instret;
    assign seq_state  = r_state;

endmodule
